inv_delay_line: RTL
===================

// Module: inv_delay_line
// PURPOSE
//  Parametrised, clocked, tap-selectable delay line with optional per-bit inversion.
//  - Samples of WIDTH bits shift through DEPTH flop stages.
//  - A runtime tap picks the delay; the inv input optionally inverts the output.
//  - Replaces single-bit gate-delay inverters in the oscillator/test datapath with a
//    deterministic, synthesizable delay.
// PARAMETERS
//  WIDTH   8   data bits per sample (>=1)
//  DEPTH   8   number of delay stages (>=2); tap width TW = $clog2(DEPTH) (localparam)
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       asynchronous active-low reset
//  en         in   1       advance enable; stages shift only when 1
//  flush      in   1       synchronous clear of all valid flags and data
//  inv        in   1       1: out_data = bitwise NOT of the selected stage
//  tap        in   TW      selected stage index 0..DEPTH-1; values >DEPTH-1 clamp to DEPTH-1
//  in_data    in   WIDTH   input sample
//  in_valid   in   1       input sample qualifier
//  out_data   out  WIDTH   registered delayed sample
//  out_valid  out  1       one-cycle pulse qualifying out_data
// BEHAVIOUR
//  - Reset (rst_n=0, async): all stage data 0, all stage valids 0, out_data=0, out_valid=0.
//  - Stage regs sd[0..DEPTH-1] (WIDTH each) and sv[0..DEPTH-1] (1 bit each).
//  - Shift on a rising edge with en=1 and flush=0:
//      sd[0]<=in_data, sv[0]<=in_valid; sd[k]<=sd[k-1], sv[k]<=sv[k-1].
//    en=0 and flush=0: all stages hold.
//  - Output reg, every edge:
//      out_valid <= en & ~flush & sv[t], where t = clamped tap.
//      out_data  <= sd[t] ^ {WIDTH{inv}} when en & ~flush; otherwise hold.
//  - Latency with en held 1: sample presented in cycle n appears on out in cycle n+t+2.
//    Each sample produces exactly one out_valid pulse; no duplicates while en=0.
//  - flush=1 (overrides en): sd/sv <= 0, out_valid <= 0, out_data <= 0.
//    An in_valid sample presented in the same cycle is discarded.
//  - tap change: takes effect at the next edge, with no drain or suppression.
//    Samples already past the new tap are lost; samples short of it may be emitted once
//    more when tap increases. The bench must not expect ordering across a tap change.
//  - inv: sampled at the output-register edge only; stage contents are never inverted.
//  - in_valid=0 samples still shift (as bubbles); they never raise out_valid.
//  - Async reset mid-stream: all in-flight samples dropped.
//    Capture resumes at the first edge after deassertion.
// CONFIGURATION
//  INV_DLY_CNT_EN defined:
//    - Adds port out_cnt (out, 16 bits): count of out_valid pulses.
//    - Increments on each cycle where out_valid=1; saturates at 16'hFFFF.
//    - Reset value 0; also cleared by flush.
//  INV_DLY_CNT_EN undefined: port and counter are absent; all other behaviour is identical.
// TESTING
//  T1 reset: rst_n=0 with random inputs -> out_data=0, out_valid=0; after release, the first
//     valid appears only after a fresh sample.
//  T2 latency: WIDTH=8, DEPTH=8, tap=3, inv=0, en=1; in_data=8'hA5 with in_valid for 1 cycle
//     at cycle 10 -> out_valid pulses in cycle 15 only, out_data=8'hA5.
//  T3 invert and clamp: DEPTH=6, tap=7 (clamps to 5), inv=1, in_data=8'h3C
//     -> out_data=8'hC3 in cycle n+7; single pulse.
//  T4 stall: tap=2; sample 8'h11 in cycle 0; en=0 in cycles 2..5 -> out_valid only in cycle 8;
//     no out_valid while en=0.
//  T5 flush: 4 valid samples in flight; flush=1 for 1 cycle together with in_valid
//     -> no out_valid for any of the 5 samples; out_data=0.
//  T6 (INV_DLY_CNT_EN): 20 valid samples -> out_cnt=20; flush -> 0;
//     force-load 16'hFFFE plus 3 pulses -> 16'hFFFF.

Source files
------------

// File: rtl/inv_delay_line.sv
// Tap-selectable clocked delay line with optional output inversion.
// Optional feature macro: INV_DLY_CNT_EN adds the saturating out_cnt pulse counter.
module inv_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     flush,
  input  logic                     inv,
  input  logic [$clog2(DEPTH)-1:0] tap,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid
`ifdef INV_DLY_CNT_EN
  ,
  output logic [15:0]              out_cnt
`endif
);

  localparam int TW = $clog2(DEPTH);
  localparam logic [TW-1:0] TAP_MAX = TW'(DEPTH - 1);

  // Handshake: valid-only stream with no backpressure. in_valid qualifies in_data
  // on an edge with en=1 and flush=0; out_valid is a one-cycle pulse qualifying out_data.

  logic [WIDTH-1:0] sd [DEPTH];
  logic [DEPTH-1:0] sv;
  logic [TW-1:0]    t;

  assign t = (tap > TAP_MAX) ? TAP_MAX : tap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) sd[k] <= '0;
      sv <= '0;
    end else if (flush) begin
      for (int k = 0; k < DEPTH; k++) sd[k] <= '0;
      sv <= '0;
    end else if (en) begin
      sd[0] <= in_data;
      for (int k = 1; k < DEPTH; k++) sd[k] <= sd[k-1];
      sv <= {sv[DEPTH-2:0], in_valid};
    end
  end

  // Inversion is applied only here, so stage contents always hold raw samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (en) begin
      out_data  <= sd[t] ^ {WIDTH{inv}};
      out_valid <= sv[t];
    end else begin
      out_valid <= 1'b0;
    end
  end

`ifdef INV_DLY_CNT_EN
  logic [15:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (out_valid && (cnt != 16'hFFFF)) begin
      cnt <= cnt + 16'd1;
    end
  end

  assign out_cnt = cnt;
`endif

endmodule
